// File: rtl/ingress_arbiter.sv
// Ingress arbiter: merges NUM_PORTS AXI-Stream sources onto the filter ingress
// one whole frame at a time, round-robin, with a forced idle gap between frames
// and a mid-frame stall timeout that closes the frame with a zero tlast beat.

package ingress_arbiter_pkg;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic              tvalid;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
  } axis_source_t;

  typedef struct packed {
    logic tready;
  } axis_sink_t;
endpackage

module ingress_arbiter
  import ingress_arbiter_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  axis_source_t                 src_source [NUM_PORTS],
  output axis_sink_t                   src_sink   [NUM_PORTS],
  output axis_source_t                 m_source,
  input  axis_sink_t                   m_sink,
  input  logic                         almost_full,
  output logic [$clog2(NUM_PORTS)-1:0] grant_id,
  output logic                         busy,
  output logic                         abort_pulse,
  output logic [15:0]                  frames_fwd,
  output logic [7:0]                   frames_aborted
);

  localparam int IDW  = $clog2(NUM_PORTS);
  localparam int GW   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0] TO_LIM   = TO_W'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0]   GAP_LOAD = GW'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   pick;
  logic             req_any;
  logic [TO_W-1:0]  to_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             grant_load;
  logic             gap_load;
  logic             fwd_done;
  logic             abort_done;
  axis_source_t     sel;

  // Aborted-frame counter sticks at its maximum instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign sel = src_source[grant_id];

  // Round-robin search for the first requester after the last granted port.
  always_comb begin
    req_any = 1'b0;
    pick    = last_grant;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!req_any && src_source[(int'(last_grant) + k) % NUM_PORTS].tvalid) begin
        req_any = 1'b1;
        pick    = IDW'((int'(last_grant) + k) % NUM_PORTS);
      end
    end
  end

  // Next-state logic; a tlast handshake takes priority over the timeout.
  always_comb begin
    state_nxt  = state;
    grant_load = 1'b0;
    gap_load   = 1'b0;
    fwd_done   = 1'b0;
    abort_done = 1'b0;
    case (state)
      IDLE: begin
        if (!almost_full && req_any) begin
          state_nxt  = GRANT;
          grant_load = 1'b1;
        end
      end
      GRANT: begin
        if (sel.tvalid && m_sink.tready && sel.tlast) begin
          fwd_done  = 1'b1;
          gap_load  = (GAP_CYCLES > 0);
          state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
        end else if ((TIMEOUT_CYCLES > 0) && (to_cnt == TO_LIM)) begin
          state_nxt = ABORT;
        end
      end
      ABORT: begin
        if (m_sink.tready) begin
          abort_done = 1'b1;
          gap_load   = (GAP_CYCLES > 0);
          state_nxt  = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt <= GW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stream steering; everything is forced quiet while reset is held low.
  always_comb begin
    m_source = '0;
    for (int i = 0; i < NUM_PORTS; i++) src_sink[i].tready = 1'b0;
    if (reset) begin
      case (state)
        GRANT: begin
          m_source                 = sel;
          src_sink[grant_id].tready = m_sink.tready;
        end
        ABORT: begin
          m_source.tvalid = 1'b1;
          m_source.tdata  = '0;
          m_source.tlast  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Status flags decoded from the current state.
  always_comb begin
    busy        = (state == GRANT) || (state == ABORT);
    abort_pulse = abort_done && reset;
  end

  // State register, grant record, timeout/gap counters and frame statistics.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      last_grant     <= IDW'(NUM_PORTS - 1);
      grant_id       <= '0;
      to_cnt         <= '0;
      gap_cnt        <= '0;
      frames_fwd     <= '0;
      frames_aborted <= '0;
    end else begin
      state <= state_nxt;
      if (grant_load) begin
        grant_id   <= pick;
        last_grant <= pick;
      end
      if (grant_load) begin
        to_cnt <= '0;
      end else if (state == GRANT) begin
        if (sel.tvalid)            to_cnt <= '0;
        else if (to_cnt != TO_LIM) to_cnt <= to_cnt + TO_W'(1);
      end
      if (gap_load) begin
        gap_cnt <= GAP_LOAD;
      end else if ((state == GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
      if (fwd_done)   frames_fwd     <= frames_fwd + 16'd1;
      if (abort_done) frames_aborted <= sat_inc8(frames_aborted);
    end
  end

endmodule

// File: tb/tb_ingress_arbiter.sv
// Directed bench for ingress_arbiter: per-port beat sources, a scoreboard of
// expected merged beats in grant order, and per-cycle handshake-legality checks.

module tb_ingress_arbiter;
  import ingress_arbiter_pkg::*;

  localparam int NP  = 4;
  localparam int GAP = 1;
  localparam int TMO = 64;

  typedef struct {
    int          port;
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  axis_source_t  src_source [NP];
  axis_sink_t    src_sink   [NP];
  axis_source_t  m_source;
  axis_sink_t    m_sink;
  logic          almost_full;
  logic [1:0]    grant_id;
  logic          busy;
  logic          abort_pulse;
  logic [15:0]   frames_fwd;
  logic [7:0]    frames_aborted;

  exp_t          sb[$];
  int            hs_cyc[$];
  int            n_assert = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            n_abort_pulses = 0;
  logic [16:0]   pmem [NP][64];
  int            wp [NP];
  int            rp [NP] = '{default: 0};

  ingress_arbiter #(.NUM_PORTS(NP), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .src_source     (src_source),
    .src_sink       (src_sink),
    .m_source       (m_source),
    .m_sink         (m_sink),
    .almost_full    (almost_full),
    .grant_id       (grant_id),
    .busy           (busy),
    .abort_pulse    (abort_pulse),
    .frames_fwd     (frames_fwd),
    .frames_aborted (frames_aborted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-port sources: present the head of each port's beat list.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      src_source[i].tvalid = (rp[i] != wp[i]);
      {src_source[i].tdata, src_source[i].tlast} = pmem[i][rp[i] % 64];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NP; i++)
      if (src_source[i].tvalid && src_sink[i].tready) rp[i] <= rp[i] + 1;
  end

  // Monitor: scoreboard pops on each merged handshake, plus tready legality.
  always @(negedge clk) begin
    exp_t        e;
    logic [NP-1:0] mask;
    logic [NP-1:0] allm;
    if (abort_pulse) n_abort_pulses++;
    if (reset && m_source.tvalid && m_sink.tready) begin
      hs_cyc.push_back(cyc);
      check("sb_expected_beat", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("beat_data", 32'(m_source.tdata), 32'(e.data));
        check("beat_last", 32'(m_source.tlast), 32'(e.last));
        check("beat_port", 32'(grant_id), 32'(e.port));
      end
    end
    for (int i = 0; i < NP; i++) begin
      mask[i] = src_sink[i].tready && (i != int'(grant_id));
      allm[i] = src_sink[i].tready;
    end
    check("tready_nongranted", 32'(mask), 32'd0);
    if (!busy) begin
      check("tready_not_busy", 32'(allm), 32'd0);
      check("tvalid_not_busy", 32'(m_source.tvalid), 32'd0);
    end
  end

  task automatic put_beat(input int p, input logic [15:0] d, input logic l);
    pmem[p][wp[p]] = {d, l};
    wp[p] = wp[p] + 1;
  endtask

  task automatic exp_beat(input int p, input logic [15:0] d, input logic l);
    exp_t e;
    e.port = p;
    e.data = d;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic frame(input int p, input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      put_beat(p, base + 16'(i), (i == n - 1));
      exp_beat(p, base + 16'(i), (i == n - 1));
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({tag, "_drain"}, 32'(sb.size()), 32'd0);
    if (sb.size() != 0) sb.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_frames_fwd", 32'(frames_fwd), 32'd0);
    check("rst_frames_aborted", 32'(frames_aborted), 32'd0);
    check("rst_abort_pulse", 32'(abort_pulse), 32'd0);
    check("rst_m_tvalid", 32'(m_source.tvalid), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int delta;
    int base;
    int n;
    reset         = 1'b0;
    almost_full   = 1'b0;
    m_sink.tready = 1'b1;
    for (int i = 0; i < NP; i++) wp[i] = 0;

    // Reset state
    do_reset();

    // Ports 0 and 2 together: port 0 first, then the gap, then port 2
    hs_cyc.delete();
    frame(0, 3, 16'h0A00);
    frame(2, 3, 16'h2A00);
    wait_drain("a", 100);
    check("a_frames_fwd", 32'(frames_fwd), 32'd2);
    check("a_nbeats", 32'(hs_cyc.size()), 32'd6);
    delta = (hs_cyc.size() >= 4) ? hs_cyc[3] - hs_cyc[2] : -1;
    check("a_frame_spacing", 32'(delta), 32'(GAP + 2));
    delta = (hs_cyc.size() >= 2) ? hs_cyc[1] - hs_cyc[0] : -1;
    check("a_back_to_back", 32'(delta), 32'd1);

    // All four ports requesting: order 0,1,2,3,0
    do_reset();
    frame(0, 2, 16'h0B00);
    frame(1, 2, 16'h1B00);
    frame(2, 2, 16'h2B00);
    frame(3, 2, 16'h3B00);
    frame(0, 2, 16'h0B10);
    wait_drain("b", 200);
    check("b_frames_fwd", 32'(frames_fwd), 32'd5);

    // almost_full holds off the grant; rising mid-frame does not truncate
    almost_full = 1'b1;
    frame(1, 4, 16'h1C00);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("c_af_no_grant", 32'(busy), 32'd0);
    check("c_af_no_beats", 32'(sb.size()), 32'd4);
    @(posedge clk); #1 almost_full = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("c_grant_after_af", 32'(busy), 32'd1);
    check("c_grant_port", 32'(grant_id), 32'd1);
    @(posedge clk); #1 almost_full = 1'b1;
    wait_drain("c", 50);
    almost_full = 1'b0;
    check("c_frames_fwd", 32'(frames_fwd), 32'd6);

    // Downstream tready toggling over a 5-beat frame
    frame(2, 5, 16'h2D00);
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk); #1 m_sink.tready = ~m_sink.tready;
      n++;
    end
    m_sink.tready = 1'b1;
    wait_drain("d", 10);
    check("d_port_consumed", 32'(wp[2] - rp[2]), 32'd0);
    check("d_frames_fwd", 32'(frames_fwd), 32'd7);

    // Mid-frame stall on port 3 ends in a zero tlast beat
    hs_cyc.delete();
    n_abort_pulses = 0;
    put_beat(3, 16'h3E00, 1'b0);
    put_beat(3, 16'h3E01, 1'b0);
    exp_beat(3, 16'h3E00, 1'b0);
    exp_beat(3, 16'h3E01, 1'b0);
    exp_beat(3, 16'h0000, 1'b1);
    wait_drain("e", 300);
    check("e_abort_pulses", 32'(n_abort_pulses), 32'd1);
    check("e_frames_aborted", 32'(frames_aborted), 32'd1);
    check("e_frames_fwd", 32'(frames_fwd), 32'd7);
    delta = (hs_cyc.size() >= 3) ? hs_cyc[2] - hs_cyc[1] : -1;
    check("e_timeout_delay", 32'((delta >= TMO + 1) && (delta <= TMO + 2)), 32'd1);

    // Reset mid-frame on port 1; port 0 is served first afterwards
    base = rp[1];
    for (int i = 0; i < 4; i++) put_beat(1, 16'h1F00 + 16'(i), (i == 3));
    exp_beat(1, 16'h1F00, 1'b0);
    exp_beat(1, 16'h1F01, 1'b0);
    n = 0;
    while ((rp[1] - base) < 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("f_reached_mid", 32'(rp[1] - base), 32'd2);
    reset = 1'b0;
    frame(0, 3, 16'h0F00);
    exp_beat(1, 16'h1F02, 1'b0);
    exp_beat(1, 16'h1F03, 1'b1);
    @(negedge clk);
    check("f_rst_tready_low", 32'(src_sink[1].tready), 32'd0);
    check("f_rst_tvalid_low", 32'(m_source.tvalid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("f_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    wait_drain("f", 100);
    check("f_frames_fwd", 32'(frames_fwd), 32'd2);
    check("f_frames_aborted", 32'(frames_aborted), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
